// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing the user LED bank between the Patmos core and the management SoC.
// Optional heartbeat blink while the bank is unowned: define LED_HEARTBEAT_EN.
module led_bank_arbiter #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1024,
    parameter int PRESCALE    = 25000
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             core_req,
    input  logic             core_wr,
    input  logic [WIDTH-1:0] core_data,
    output logic             core_gnt,
    input  logic             mgmt_req,
    input  logic             mgmt_wr,
    input  logic [WIDTH-1:0] mgmt_data,
    output logic             mgmt_gnt,
    output logic [WIDTH-1:0] led_out,
    output logic [WIDTH-1:0] led_oeb,
    output logic [1:0]       owner
);

    // State encoding doubles as the owner code, so owner and the grants decode straight from the register.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CORE = 2'b01,
        MGMT = 2'b10
    } state_t;

    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

    generate
        if (HOLD_CYCLES < 2 || PRESCALE < 2) begin : g_param_check
            $error("led_bank_arbiter: HOLD_CYCLES and PRESCALE must both be >= 2");
        end
    endgenerate

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] hold_cnt;
    logic          last_mgmt;
    logic          last_mgmt_next;
    logic          core_wr_ok;
    logic          mgmt_wr_ok;

    always_comb begin
        state_next     = state;
        last_mgmt_next = last_mgmt;
        case (state)
            IDLE: begin
                if (core_req && mgmt_req) begin
                    state_next = last_mgmt ? CORE : MGMT;
                end else if (core_req) begin
                    state_next = CORE;
                end else if (mgmt_req) begin
                    state_next = MGMT;
                end
            end
            CORE: begin
                if (!core_req || (hold_cnt == HOLD_MAX && mgmt_req)) begin
                    state_next     = IDLE;
                    last_mgmt_next = 1'b0;
                end
            end
            MGMT: begin
                if (!mgmt_req || (hold_cnt == HOLD_MAX && core_req)) begin
                    state_next     = IDLE;
                    last_mgmt_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every grant is entered from IDLE, so clearing the hold counter there is the same as clearing on entry.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            last_mgmt <= 1'b1;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            last_mgmt <= last_mgmt_next;
            if (state == IDLE) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign core_gnt   = (state == CORE);
    assign mgmt_gnt   = (state == MGMT);
    assign owner      = state;
    assign core_wr_ok = (state == CORE) && core_wr;
    assign mgmt_wr_ok = (state == MGMT) && mgmt_wr;

`ifdef LED_HEARTBEAT_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] prescale_cnt;
    logic          beat;

    assign beat = (state == IDLE) && (prescale_cnt == PRE_MAX);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            prescale_cnt <= '0;
        end else if (state != IDLE || beat) begin
            prescale_cnt <= '0;
        end else begin
            prescale_cnt <= prescale_cnt + 1'b1;
        end
    end

    // Writes and heartbeat never coincide: writes need an owner, the heartbeat only runs in IDLE.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            led_out <= '0;
            led_oeb <= '1;
        end else if (core_wr_ok) begin
            led_out <= core_data;
            led_oeb <= '0;
        end else if (mgmt_wr_ok) begin
            led_out <= mgmt_data;
            led_oeb <= '0;
        end else if (beat) begin
            led_out[0] <= ~led_out[0];
            led_oeb[0] <= 1'b0;
        end
    end
`else
    // The pad enables only ever fall, so the bank stays hi-Z until someone actually writes it.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            led_out <= '0;
            led_oeb <= '1;
        end else if (core_wr_ok) begin
            led_out <= core_data;
            led_oeb <= '0;
        end else if (mgmt_wr_ok) begin
            led_out <= mgmt_data;
            led_oeb <= '0;
        end
    end
`endif

endmodule
